// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx
// Receives the PS/2 keyboard stream in the clk_sys domain. It checks each
// 11-bit frame, folds the E0 (extended) and F0 (break) prefixes into one key
// event, and queues the events in a small FIFO.
//
// Optional feature macro: PS2_KBD_RX_TIMEOUT_EN. When it is defined, a partial
// frame is abandoned after TIMEOUT cycles with no PS/2 falling edge.
//
// Parameters:
//   FIFO_BITS    event FIFO depth = 2**FIFO_BITS entries
//   TIMEOUT      idle cycles before a partial frame is dropped (macro on)
// Ports:
//   clk_sys      system clock
//   reset        asynchronous, active-high reset
//   ps2_clk      PS/2 clock line (asynchronous)
//   ps2_data     PS/2 data line (asynchronous)
//   key_rd       pop the FIFO head (ignored when empty)
//   key_valid    FIFO not empty
//   key_code     scancode at the head (0 when empty)
//   key_pressed  1 = make, 0 = break (0 when empty)
//   key_extended E0 prefix seen (0 when empty)
//   frame_err    one-cycle pulse on a parity, stop or timeout error
//   overflow     sticky flag: an event was dropped because the FIFO was full
//
// state    | meaning
// ---------+---------------------------------------------
// S_IDLE   | waiting for a start bit (data=0 on a falling edge)
// S_DATA   | shifting in 8 data bits, LSB first
// S_PARITY | waiting for the parity bit
// S_STOP   | waiting for the stop bit; the frame is judged on its edge
module ps2_kbd_rx #(
  parameter int FIFO_BITS = 2,
  parameter int TIMEOUT   = 20000
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_rd,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       frame_err,
  output logic       overflow
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  localparam int DEPTH = 1 << FIFO_BITS;

  state_t r_state;
  state_t w_state_nxt;

  logic       r_clk_s1, r_clk_s2, r_clk_prev;
  logic       r_dat_s1, r_dat_s2;
  logic       w_fe;
  logic       w_bit;

  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic       r_parity;
  logic       r_ext_f;
  logic       r_brk_f;
  logic       r_frame_err;
  logic       r_overflow;

  logic       w_frame_done;
  logic       w_frame_ok;
  logic       w_is_prefix;
  logic       w_push_req;
  logic       w_bad;
  logic       w_timeout;

  logic [9:0]         r_mem [DEPTH];
  logic [FIFO_BITS:0] r_wptr, r_rptr;
  logic               w_empty, w_full;
  logic               w_pop, w_wr, w_drop;
  logic [9:0]         w_head;

  // Synchronizers reset to 1 so an idle-high line never looks like an edge.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
    end
  end

  assign w_fe  = r_clk_prev & ~r_clk_s2;
  assign w_bit = r_dat_s2;

`ifdef PS2_KBD_RX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] r_to_cnt;

  // An edge in the same cycle as the limit wins: the frame carries on.
  assign w_timeout = (r_state != S_IDLE) && !w_fe && (r_to_cnt == TO_W'(TIMEOUT));

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == S_IDLE || w_fe || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  // TIMEOUT only matters when the timeout counter is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      S_IDLE:   if (w_fe && !w_bit) w_state_nxt = S_DATA;
      S_DATA:   if (w_fe && r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
      S_PARITY: if (w_fe) w_state_nxt = S_STOP;
      S_STOP: begin
        if (w_fe) begin
          w_state_nxt  = S_IDLE;
          w_frame_done = 1'b1;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
    if (w_timeout) w_state_nxt = S_IDLE;
  end

  // Odd parity over data+parity, and the stop bit (sampled now) must be 1.
  assign w_frame_ok  = (^{r_shift, r_parity}) & w_bit;
  assign w_is_prefix = (r_shift == 8'hE0) || (r_shift == 8'hF0);
  assign w_push_req  = w_frame_done & w_frame_ok & ~w_is_prefix;
  assign w_bad       = (w_frame_done & ~w_frame_ok) | w_timeout;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_ext_f     <= 1'b0;
      r_brk_f     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_bad;
      if (r_state == S_IDLE && w_fe && !w_bit) begin
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (r_state == S_DATA && w_fe) begin
        r_shift   <= {w_bit, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      if (r_state == S_PARITY && w_fe) r_parity <= w_bit;

      if (w_bad) begin
        r_ext_f <= 1'b0;
        r_brk_f <= 1'b0;
      end else if (w_frame_done && w_frame_ok) begin
        if (r_shift == 8'hE0) begin
          r_ext_f <= 1'b1;
        end else if (r_shift == 8'hF0) begin
          r_brk_f <= 1'b1;
        end else begin
          r_ext_f <= 1'b0;
          r_brk_f <= 1'b0;
        end
      end
    end
  end

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[FIFO_BITS] != r_rptr[FIFO_BITS]) &&
                   (r_wptr[FIFO_BITS-1:0] == r_rptr[FIFO_BITS-1:0]);
  assign w_pop   = key_rd & ~w_empty;
  assign w_wr    = w_push_req & (~w_full | w_pop);
  assign w_drop  = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wptr[FIFO_BITS-1:0]] <= {r_ext_f, ~r_brk_f, r_shift};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)   r_wptr     <= r_wptr + 1'b1;
      if (w_pop)  r_rptr     <= r_rptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Head entry is masked so the outputs read 0 whenever the FIFO is empty.
  assign w_head       = r_mem[r_rptr[FIFO_BITS-1:0]];
  assign key_valid    = ~w_empty;
  assign key_code     = w_head[7:0] & {8{key_valid}};
  assign key_pressed  = w_head[8] & key_valid;
  assign key_extended = w_head[9] & key_valid;
  assign frame_err    = r_frame_err;
  assign overflow     = r_overflow;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Testbench for ps2_kbd_rx: drives PS/2 frames, keeps a byte-level event
// model (queue plus prefix flags) and compares the DUT against it every cycle.
module tb_ps2_kbd_rx;

  logic       clk_sys  = 1'b0;
  logic       reset    = 1'b1;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_rd   = 1'b0;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_pressed;
  logic       key_extended;
  logic       frame_err;
  logic       overflow;

  ps2_kbd_rx #(.FIFO_BITS(2), .TIMEOUT(1000)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_rd       (key_rd),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .frame_err    (frame_err),
    .overflow     (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [7:0] code;
    logic       pressed;
    logic       ext;
  } ev_t;

  ev_t q[$];
  bit  m_ext, m_brk, m_ovf;
  int  exp_err = 0, err_seen = 0;
  int  tests = 0, fails = 0;
  bit  settle = 1'b0;
  int  cyc = 0;
  int  last_fall_cyc = 0;
  int  first_err_cyc = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, sampled away from the edge.
  ev_t h;
  always begin
    @(posedge clk_sys);
    #2;
    cyc++;
    if (frame_err === 1'b1) begin
      err_seen++;
      if (first_err_cyc < 0) first_err_cyc = cyc;
    end
    if (!settle) begin
      h = (q.size() != 0) ? q[0] : '0;
      check("cycle_outputs",
            {19'd0, key_valid, key_code, key_pressed, key_extended, frame_err, overflow},
            {19'd0, (q.size() != 0), h.code, h.pressed, h.ext, 1'b0, m_ovf});
    end
  end

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else begin
      if (q.size() < 4) q.push_back(ev_t'({b, ~m_brk, m_ext}));
      else m_ovf = 1'b1;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  // One PS/2 bit: data set while the clock is high, 21-cycle low phase.
  task automatic ps2_bit(input logic b);
    @(negedge clk_sys);
    ps2_data = b;
    repeat (10) @(negedge clk_sys);
    ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (21) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (11) @(negedge clk_sys);
  endtask

  // Stop bit; the model is updated once the frame outcome has settled.
  // With pop_at, key_rd is raised for the cycle in which the push lands.
  task automatic ps2_stop(input logic sb, input logic [7:0] b, input bit good, input bit pop_at);
    @(negedge clk_sys);
    ps2_data = sb;
    repeat (10) @(negedge clk_sys);
    settle  = 1'b1;
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk_sys);
    if (pop_at) key_rd = 1'b1;
    @(negedge clk_sys);
    key_rd = 1'b0;
    repeat (5) @(negedge clk_sys);
    if (pop_at && q.size() != 0) void'(q.pop_front());
    model_frame(b, good);
    check("err_count", err_seen, exp_err);
    settle = 1'b0;
    repeat (13) @(negedge clk_sys);
    ps2_clk = 1'b1;
    repeat (11) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok, input bit pop_at);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par_ok ? ~^b : ^b);
    ps2_stop(stop_ok, b, par_ok && stop_ok, pop_at);
  endtask

  task automatic pop();
    @(negedge clk_sys);
    key_rd = 1'b1;
    if (q.size() != 0) void'(q.pop_front());
    @(negedge clk_sys);
    key_rd = 1'b0;
  endtask

  task automatic head_is(input string name, input logic [7:0] code, input logic pr, input logic ex);
    check(name, {21'd0, key_valid, key_code, key_pressed, key_extended},
                {21'd0, 1'b1, code, pr, ex});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [7:0] pb;
    int d;
    repeat (3) @(negedge clk_sys);
    check("reset_outputs",
          {26'd0, key_valid, key_pressed, key_extended, frame_err, overflow, (key_code != 0)}, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);

    // A clock pulse with data high in idle is not a start bit.
    ps2_bit(1'b1);
    check("idle_no_start", {30'd0, key_valid, frame_err}, 32'd0);

    // Make code.
    send_frame(8'h1C, 1, 1, 0);
    head_is("make_1c", 8'h1C, 1'b1, 1'b0);
    pop();
    check("make_popped", {23'd0, key_valid, key_code}, 32'd0);

    // Extended break.
    send_frame(8'hE0, 1, 1, 0);
    send_frame(8'hF0, 1, 1, 0);
    check("prefix_no_event", {31'd0, key_valid}, 32'd0);
    send_frame(8'h75, 1, 1, 0);
    head_is("ext_break_75", 8'h75, 1'b0, 1'b1);
    pop();
    check("ext_break_one", {31'd0, key_valid}, 32'd0);

    // Bad parity after a prefix, then a good frame.
    send_frame(8'hE0, 1, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("bad_par_err", err_seen, 32'd1);
    check("bad_par_no_ev", {31'd0, key_valid}, 32'd0);
    send_frame(8'h1C, 1, 1, 0);
    head_is("after_bad_1c", 8'h1C, 1'b1, 1'b0);
    pop();

    // Bad stop bit after F0 clears the break flag.
    send_frame(8'hF0, 1, 1, 0);
    send_frame(8'h22, 1, 0, 0);
    check("bad_stop_err", err_seen, 32'd2);
    send_frame(8'h1C, 1, 1, 0);
    head_is("after_stop_1c", 8'h1C, 1'b1, 1'b0);
    pop();

    // Overflow: five pushes into four entries.
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1, 1, 0);
    check("ovf_set", {31'd0, overflow}, 32'd1);
    head_is("ovf_head", 8'h01, 1'b1, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      head_is("ovf_drain", 8'(i), 1'b1, 1'b0);
      pop();
    end
    check("ovf_empty", {31'd0, key_valid}, 32'd0);

    // Reset in the middle of a frame.
    send_frame(8'h33, 1, 1, 0);
    check("pre_reset", {30'd0, key_valid, overflow}, 32'd3);
    pb = 8'h44;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(pb[i]);
    @(negedge clk_sys);
    ps2_data = pb[4];
    repeat (5) @(negedge clk_sys);
    #2;
    reset = 1'b1;
    q.delete();
    m_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    #1;
    check("reset_async",
          {19'd0, key_valid, key_code, key_pressed, key_extended, frame_err, overflow}, 32'd0);
    repeat (3) @(negedge clk_sys);
    ps2_data = 1'b1;
    reset    = 1'b0;
    repeat (5) @(negedge clk_sys);
    send_frame(8'h5A, 1, 1, 0);
    head_is("post_reset_5a", 8'h5A, 1'b1, 1'b0);
    pop();
    check("post_reset_one", {31'd0, key_valid}, 32'd0);

    // Full FIFO with push and pop in the same cycle.
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1, 1, 0);
    send_frame(8'h15, 1, 1, 1);
    check("simul_no_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      head_is("simul_drain", 8'h12 + 8'(i), 1'b1, 1'b0);
      pop();
    end
    check("simul_empty", {31'd0, key_valid}, 32'd0);

    // Stalled frame after 5 data bits, with an E0 prefix pending.
    send_frame(8'hE0, 1, 1, 0);
    pb = 8'hFF;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(pb[i]);
`ifdef PS2_KBD_RX_TIMEOUT_EN
    settle = 1'b1;
    first_err_cyc = -1;
    repeat (1200) @(negedge clk_sys);
    model_frame(pb, 0);
    check("timeout_err", err_seen, exp_err);
    d = first_err_cyc - last_fall_cyc;
    tests++;
    if (first_err_cyc < 0 || d < 990 || d > 1020) begin
      fails++;
      $display("FAIL timeout_latency: got %0d cycles after last edge, expected 990..1020", d);
    end
    check("timeout_no_ev", {31'd0, key_valid}, 32'd0);
    settle = 1'b0;
    send_frame(8'h29, 1, 1, 0);
    head_is("after_to_29", 8'h29, 1'b1, 1'b0);
    pop();
`else
    d = 0;
    repeat (1200) @(negedge clk_sys);
    check("stall_no_err", err_seen, exp_err);
    for (int i = 5; i < 8; i++) ps2_bit(pb[i]);
    ps2_bit(~^pb);
    ps2_stop(1'b1, pb, 1, 0);
    head_is("stall_resume_ff", 8'hFF, 1'b1, 1'b1);
    pop();
`endif
    check("final_empty", {31'd0, key_valid}, 32'd0);

    repeat (10) @(negedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

- Receives the PS/2 keyboard serial stream (`ps2_kbd_clk` / `ps2_kbd_data` from the SPI user I/O block) in the `clk_sys` domain.
- Validates each 11-bit frame and folds the E0/F0 prefixes into key events.
- Queues events in a small FIFO for the core's keyboard matrix logic.
- It is the stage directly downstream of the PS/2 emulation transmitter.

## Interface

- `FIFO_BITS`, default 2: event FIFO depth = 2**FIFO_BITS entries.
- `TIMEOUT`, default 20000: `clk_sys` cycles without a PS/2 falling edge before a partial frame is abandoned.
- `clk_sys` in 1: system clock. One clock domain.
- `reset` in 1: reset, asynchronous, active-high.
- `ps2_clk` in 1: PS/2 clock line, asynchronous to `clk_sys`.
- `ps2_data` in 1: PS/2 data line, asynchronous to `clk_sys`.
- `key_rd` in 1: pops the FIFO head. Ignored when `key_valid`=0.
- `key_valid` out 1: FIFO not empty.
- `key_code` out 8: scancode at FIFO head. Reads 0 when empty.
- `key_pressed` out 1: 1 = make, 0 = break (F0 seen). Reads 0 when empty.
- `key_extended` out 1: E0 prefix seen. Reads 0 when empty.
- `frame_err` out 1: one-cycle pulse on a parity, stop or timeout error.
- `overflow` out 1: sticky. Set when an event is dropped because the FIFO is full. Cleared only by `reset`.

## Operation

- **Input conditioning:** `ps2_clk` and `ps2_data` each pass through a 2-FF synchronizer. A third register holds the previous synchronized clock. A falling edge (fe) is prev=1 & sync=0. Data is sampled from the synchronized data on fe.
- **States:** IDLE, DATA, PARITY, STOP.
  - IDLE: on fe with data=0 → DATA, with bit counter=0 and shift register cleared. On fe with data=1 → stay in IDLE, no error.
  - DATA: on fe, shift the bit in LSB-first and increment the counter. After the 8th bit → PARITY.
  - PARITY: on fe, store the bit → STOP.
  - STOP: on fe, evaluate the frame → IDLE.
- **Frame check:** the frame is good iff XOR(data[7:0], parity)=1 (odd parity) and stop=1.
- **Good byte handling:**
  - 0xE0: set `ext_f`. Nothing is pushed.
  - 0xF0: set `brk_f`. Nothing is pushed.
  - Any other byte (including 0xE1): push {code, pressed=~brk_f, extended=ext_f}, then clear both flags.
- **Bad frame:** `frame_err`=1 for one cycle, byte discarded, `ext_f` and `brk_f` cleared.
- **FIFO:**
  - Write and read pointers are FIFO_BITS+1 wide. Full and empty are decided by MSB/low-bit comparison. Pointers wrap naturally.
  - Push when full with no pop: event dropped, `overflow` set.
  - Push and pop in the same cycle when full: both take effect, no overflow.
  - Push and pop in the same cycle when empty: the push takes effect and the pop is ignored.
- **Outputs:** `key_code`/`key_pressed`/`key_extended` are the head entry, ANDed with `key_valid`.

## Timing

- **Reset values:** state=IDLE, pointers=0, flags=0, synchronizers=1. Outputs: `key_valid`=0, `key_code`=0, `key_pressed`=0, `key_extended`=0, `frame_err`=0, `overflow`=0.
- **Reset mid-frame:** the partial frame is lost. Decoding restarts at the next start bit.
- **Edge latency:** an input falling edge becomes fe 2–3 `clk_sys` cycles later (synchronizer uncertainty).
- **Stop-bit latency:** a stop-bit fe in cycle E gives `key_valid`=1 and head data from cycle E+1. `frame_err` is high exactly in cycle E+1.
- **Pop:** with `key_rd`=1 in cycle P, the next entry (or empty) is visible in cycle P+1.
- **Rate:** back-to-back events are supported at PS/2 rate. The FIFO accepts one push per cycle.
- **Line rate:** `ps2_clk` high and low phases must each be ≥ 3 `clk_sys` cycles. With PS2DIV=20 they are 21 cycles.

## Configuration

- **`PS2_KBD_RX_TIMEOUT_EN` defined:**
  - A counter of width $clog2(TIMEOUT+1) clears on every fe and on entry to IDLE.
  - It increments each cycle while the state is not IDLE.
  - When it reaches TIMEOUT: state → IDLE, `frame_err` pulses for one cycle, `ext_f` and `brk_f` are cleared.
  - A fe and the timeout in the same cycle: the fe wins.
- **Not defined:** no counter. A partial frame waits indefinitely for further edges. `TIMEOUT` is unused.

## Test plan

- **Make code:** frame 0x1C, odd parity 0, stop 1 → `key_valid`=1, `key_code`=0x1C, `key_pressed`=1, `key_extended`=0. `key_rd` pulse → `key_valid`=0 and all head outputs 0 next cycle.
- **Extended break:** frames E0, F0, 75 → exactly one event: `key_code`=0x75, `key_pressed`=0, `key_extended`=1. No event for the prefixes.
- **Bad parity after prefix:** E0 then 0x1C with wrong parity → one `frame_err` pulse, no event. A following good 0x1C → `key_extended`=0.
- **Overflow:** with FIFO_BITS=2, push 5 events without popping → `overflow`=1, head=first event, four pops return events 1–4. Repeat the full case with push and pop in the same cycle → `overflow` stays 0.
- **Timeout (macro on, TIMEOUT=1000):** stop `ps2_clk` after 5 data bits → `frame_err` about 1000 cycles after the last fe, no event. The next good frame 0x29 decodes correctly.
- **Reset mid-frame:** assert `reset` during bit 4 → all outputs 0 immediately. After release, frame 0x5A → one event 0x5A with `key_pressed`=1.
